// File: rtl/score_render.sv
// rtl/score_render.sv - per-frame BCD score snapshot, high-score tracking and 7-segment overlay renderer
module score_render #(
  parameter int X0 = 560,
  parameter int Y0 = 16,
  parameter int S  = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] score,
  input  logic        game_tick,
  input  logic        game_over,
  input  logic [9:0]  hpos,
  input  logic [9:0]  vpos,
  output logic        pixel_on,
  output logic [15:0] hi_score
);

  localparam logic [10:0] X0_L = 11'(X0);
  localparam logic [10:0] Y0_L = 11'(Y0);
  localparam logic [10:0] W_L  = 11'(20 << S);
  localparam logic [10:0] H_L  = 11'(15 << S);

  logic        tick_q;
  logic [15:0] snap_q, hi_q;
  logic        in_q, sel_q, pix_q;
  logic [1:0]  slot_q;
  logic [2:0]  col_q, row_q;

  logic [10:0] dx, dy;
  logic [4:0]  gx;
  logic [3:0]  gy;
  logic        in_d, sel_d;
  logic [1:0]  slot_d;
  logic [2:0]  col_d, row_d;

  // Stage 1: 11-bit offsets keep left/above-region pixels negative instead of wrapping in.
  always_comb begin
    dx     = {1'b0, hpos} - X0_L;
    dy     = {1'b0, vpos} - Y0_L;
    in_d   = ~dx[10] & ~dy[10] & (dx < W_L) & (dy < H_L);
    gx     = 5'(dx >> S);
    gy     = 4'(dy >> S);
    slot_d = 2'd0;
    col_d  = 3'(gx);
    if (gx >= 5'd15) begin
      slot_d = 2'd3;
      col_d  = 3'(gx - 5'd15);
    end else if (gx >= 5'd10) begin
      slot_d = 2'd2;
      col_d  = 3'(gx - 5'd10);
    end else if (gx >= 5'd5) begin
      slot_d = 2'd1;
      col_d  = 3'(gx - 5'd5);
    end
    // gy 7 maps to row 7, which no segment covers, so the middle gap needs no extra flag.
    sel_d = (gy >= 4'd8);
    row_d = sel_d ? 3'(gy - 4'd8) : gy[2:0];
  end

  logic [15:0] digs;
  logic [3:0]  nib;
  logic        blank, hit;
  logic [6:0]  seg;  // {a,b,c,d,e,f,g}

  always_comb begin
    digs = sel_q ? hi_q : snap_q;
    nib  = 4'd0;
    blank = 1'b0;
    case (slot_q)
      2'd0: begin nib = digs[15:12]; blank = (digs[15:12] == 4'd0); end
      2'd1: begin nib = digs[11:8];  blank = (digs[15:8]  == 8'd0); end
      2'd2: begin nib = digs[7:4];   blank = (digs[15:4]  == 12'd0); end
      default: begin nib = digs[3:0]; blank = 1'b0; end
    endcase
    case (nib)
      4'd0: seg = 7'b1111110;
      4'd1: seg = 7'b0110000;
      4'd2: seg = 7'b1101101;
      4'd3: seg = 7'b1111001;
      4'd4: seg = 7'b0110011;
      4'd5: seg = 7'b1011011;
      4'd6: seg = 7'b1011111;
      4'd7: seg = 7'b1110000;
      4'd8: seg = 7'b1111111;
      4'd9: seg = 7'b1111011;
      default: seg = 7'b0000001;
    endcase
    hit = (seg[6] & (row_q == 3'd0))
        | (seg[5] & (col_q == 3'd3) & (row_q <= 3'd3))
        | (seg[4] & (col_q == 3'd3) & (row_q >= 3'd3) & (row_q <= 3'd6))
        | (seg[3] & (row_q == 3'd6))
        | (seg[2] & (col_q == 3'd0) & (row_q >= 3'd3) & (row_q <= 3'd6))
        | (seg[1] & (col_q == 3'd0) & (row_q <= 3'd3))
        | (seg[0] & (row_q == 3'd3));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_q <= 1'b0;
      snap_q <= 16'd0;
      hi_q   <= 16'd0;
      in_q   <= 1'b0;
      sel_q  <= 1'b0;
      slot_q <= 2'd0;
      col_q  <= 3'd0;
      row_q  <= 3'd0;
      pix_q  <= 1'b0;
    end else begin
      tick_q <= game_tick;
      if (tick_q) snap_q <= score;
      if (game_over && (score > hi_q)) hi_q <= score;
      in_q   <= in_d;
      sel_q  <= sel_d;
      slot_q <= slot_d;
      col_q  <= col_d;
      row_q  <= row_d;
      pix_q  <= in_q & (col_q != 3'd4) & ~blank & hit;
    end
  end

  assign pixel_on = pix_q;
  assign hi_score = hi_q;

endmodule

// File: tb/tb_score_render.sv
// tb/tb_score_render.sv - directed self-checking bench for score_render
module tb_score_render;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] score;
  logic        game_tick, game_over;
  logic [9:0]  hpos, vpos;
  logic        pixel_on;
  logic [15:0] hi_score;

  int total = 0;
  int bad   = 0;

  score_render #(.X0(560), .Y0(16), .S(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .score     (score),
    .game_tick (game_tick),
    .game_over (game_over),
    .hpos      (hpos),
    .vpos      (vpos),
    .pixel_on  (pixel_on),
    .hi_score  (hi_score)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic probe(input int h, input int v, input logic exp, input string tag);
    @(negedge clk);
    hpos = 10'(h);
    vpos = 10'(v);
    @(posedge clk);
    @(posedge clk);
    #1;
    check(tag, {15'd0, pixel_on}, {15'd0, exp});
  endtask

  task automatic pulse_tick();
    @(negedge clk);
    game_tick = 1'b1;
    @(negedge clk);
    game_tick = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_over(input logic [15:0] exp_hi, input string tag);
    @(negedge clk);
    game_over = 1'b1;
    @(posedge clk);
    #1;
    check(tag, hi_score, exp_hi);
    @(negedge clk);
    game_over = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    score = 16'h0000;
    game_tick = 1'b0;
    game_over = 1'b0;
    hpos = 10'd590;
    vpos = 10'd16;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pixel", {15'd0, pixel_on}, 16'd0);
    check("rst_hi", hi_score, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    probe(590, 16, 1'b1, "rst_zero_seg_a");
    probe(560, 16, 1'b0, "rst_blank_slot0");
    check("hi_after_rst", hi_score, 16'h0000);

    score = 16'h0042;
    pulse_tick();
    probe(582, 16, 1'b0, "s42_no_seg_a");
    @(negedge clk);
    hpos = 10'd580;
    vpos = 10'd22;
    @(posedge clk);
    #1;
    check("latency_1cyc", {15'd0, pixel_on}, 16'd0);
    @(posedge clk);
    #1;
    check("latency_2cyc", {15'd0, pixel_on}, 16'd1);
    probe(572, 22, 1'b0, "s42_blank_slot1");

    score = 16'h0043;
    probe(590, 26, 1'b1, "tear_hold_2e");
    pulse_tick();
    probe(590, 26, 1'b0, "tear_new_3");

    score = 16'h0123;
    pulse_over(16'h0123, "hi_update");
    score = 16'h0099;
    pulse_over(16'h0123, "hi_keep_lower");
    score = 16'h0123;
    pulse_over(16'h0123, "hi_keep_equal");
    probe(590, 32, 1'b1, "hi_3_seg_a");
    probe(590, 45, 1'b1, "hi_3_seg_d");
    probe(560, 32, 1'b0, "hi_blank_slot0");

    score = 16'h000A;
    pulse_tick();
    probe(590, 22, 1'b1, "dash_g");
    probe(590, 16, 1'b0, "dash_no_a");

    probe(559, 16, 1'b0, "left_edge");
    probe(600, 16, 1'b0, "right_edge");
    probe(590, 15, 1'b0, "top_edge");
    probe(590, 46, 1'b0, "bottom_edge");
    probe(598, 22, 1'b0, "slot3_col4_gap");
    probe(568, 22, 1'b0, "slot0_col4_gap");
    probe(590, 30, 1'b0, "gy7_gap");

    probe(590, 22, 1'b1, "pre_reset_on");
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_pixel", {15'd0, pixel_on}, 16'd0);
    check("midreset_hi", hi_score, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
